// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and sizing helpers for the UART receive buffer and its FIFO.
package uart_rx_fifo_pkg;

   localparam int DEFAULT_DATA_BIT_COUNT = 8;
   localparam int DEFAULT_DEPTH          = 16;

   // Pointers and level carry one bit beyond the address so full and empty differ.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extended-pointer full/empty detection.
module sync_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_BIT_COUNT,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              do_pop;
   logic              do_push;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   // A pop on the same edge frees the slot the push lands in, so a full FIFO still accepts.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage has no reset; stale entries are unobservable while the pointers say empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: captures each byte once on the receiver's ready edge,
// queues it, and hands it to the console mux over valid/ready with a sticky overflow flag.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_BIT_COUNT = DEFAULT_DATA_BIT_COUNT,
   parameter int DEPTH          = DEFAULT_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_ready,
   input  logic [DATA_BIT_COUNT-1:0]     rx_data,
   output logic                          out_valid,
   output logic [DATA_BIT_COUNT-1:0]     out_data,
   input  logic                          out_ready,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          overflow,
   input  logic                          clear_overflow
);

   logic rx_ready_q;
   logic push;
   logic pop;
   logic full;
   logic empty;
   logic drop;

   assign push      = rx_ready & ~rx_ready_q;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign drop      = push & full & ~pop;

   // rx_ready_q resets high so a flag still asserted across reset is not taken as a new byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ready_q <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         rx_ready_q <= rx_ready;
         if (drop)                overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end

   sync_fifo #(
      .DATA_W (DATA_BIT_COUNT),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (rx_data),
      .pop       (pop),
      .pop_data  (out_data),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed scenarios.
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_ready;
   logic [DW-1:0] rx_data;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [LW-1:0] level;
   logic          overflow;
   logic          clear_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] m_q[$];
   logic [DW-1:0] exp_stream[$];
   logic [DW-1:0] dut_stream[$];
   logic          m_ovf;
   logic          m_prev;

   uart_rx_fifo #(.DATA_BIT_COUNT(DW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_ready       (rx_ready),
      .rx_data        (rx_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .level          (level),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue; a new byte arrives on each low-to-high ready transition,
   // the consumer removes the head when it is ready, and arrivals into a queue that is
   // still DEPTH long after that removal are lost and latch the overflow flag.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_ovf  <= 1'b0;
         m_prev <= 1'b1;
      end else begin
         if (out_ready && m_q.size() != 0) begin
            exp_stream.push_back(m_q[0]);
            void'(m_q.pop_front());
         end
         if (rx_ready && !m_prev && m_q.size() >= DEPTH) m_ovf <= 1'b1;
         else if (clear_overflow)                        m_ovf <= 1'b0;
         if (rx_ready && !m_prev && m_q.size() < DEPTH) m_q.push_back(rx_data);
         m_prev <= rx_ready;
      end
   end

   // Every-cycle comparison away from the active edge; also logs what the DUT hands over.
   always @(negedge clk) begin
      if (!rst) begin
         check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         check("level", 32'(level), 32'(m_q.size()));
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
         if (out_valid && out_ready) dut_stream.push_back(out_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [DW-1:0] d, input int hold);
      rx_data  = d;
      rx_ready = 1'b1;
      repeat (hold) step();
      rx_ready = 1'b0;
      step();
   endtask

   task automatic drain(input int cycles);
      out_ready = 1'b1;
      repeat (cycles) step();
      out_ready = 1'b0;
   endtask

   initial begin
      int aa_seen;
      rst            = 1'b1;
      rx_ready       = 1'b1;
      rx_data        = 8'h99;
      out_ready      = 1'b0;
      clear_overflow = 1'b0;
      repeat (3) step();

      // 1: ready held high through reset release must not be captured
      rst = 1'b0;
      repeat (3) step();
      check("t1_level", 32'(level), 32'd0);
      check("t1_valid", 32'(out_valid), 32'd0);
      rx_ready = 1'b0;
      step();

      // 2: one long ready pulse gives exactly one entry
      send_byte(8'h41, 20);
      check("t2_level", 32'(level), 32'd1);
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_data", 32'(out_data), 32'h41);
      drain(1);
      check("t2_empty", 32'(level), 32'd0);

      // 3: fill to DEPTH then drain in order
      for (int i = 0; i < DEPTH; i++) send_byte(DW'(i), 1);
      check("t3_full_level", 32'(level), 32'd16);
      dut_stream.delete();
      drain(DEPTH);
      check("t3_level_after", 32'(level), 32'd0);
      check("t3_count", 32'(dut_stream.size()), 32'd16);
      for (int i = 0; i < DEPTH && i < dut_stream.size(); i++)
         check("t3_order", 32'(dut_stream[i]), 32'(i));
      check("t3_overflow", 32'(overflow), 32'd0);

      // 4: push into a full FIFO with no pop drops the byte and sets overflow
      for (int i = 0; i < DEPTH; i++) send_byte(8'h80 + DW'(i), 1);
      send_byte(8'hAA, 1);
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_level", 32'(level), 32'd16);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      check("t4_cleared", 32'(overflow), 32'd0);
      dut_stream.delete();
      drain(DEPTH + 2);
      aa_seen = 0;
      foreach (dut_stream[i]) if (dut_stream[i] == 8'hAA) aa_seen++;
      check("t4_aa_absent", 32'(aa_seen), 32'd0);
      check("t4_count", 32'(dut_stream.size()), 32'd16);

      // 5: push on the same edge as a pop while full is accepted
      for (int i = 0; i < DEPTH; i++) send_byte(8'h60 + DW'(i), 1);
      rx_data   = 8'h55;
      rx_ready  = 1'b1;
      out_ready = 1'b1;
      dut_stream.delete();
      step();
      out_ready = 1'b0;
      rx_ready  = 1'b0;
      step();
      check("t5_level", 32'(level), 32'd16);
      check("t5_overflow", 32'(overflow), 32'd0);
      drain(DEPTH + 2);
      check("t5_count", 32'(dut_stream.size()), 32'd17);
      if (dut_stream.size() == 17) begin
         check("t5_first", 32'(dut_stream[0]), 32'h60);
         check("t5_head", 32'(dut_stream[1]), 32'h61);
         check("t5_last", 32'(dut_stream[16]), 32'h55);
      end

      // 6: asynchronous reset mid-stream discards everything at once
      for (int i = 0; i < 5; i++) send_byte(8'h10 + DW'(i), 1);
      check("t6_level5", 32'(level), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_valid", 32'(out_valid), 32'd0);
      check("t6_async_level", 32'(level), 32'd0);
      step();
      rst = 1'b0;
      step();
      send_byte(8'h77, 2);
      check("t6_next_data", 32'(out_data), 32'h77);
      check("t6_next_level", 32'(level), 32'd1);
      drain(2);

      // 7: wrap-around with random consumer back-pressure
      exp_stream.delete();
      dut_stream.delete();
      for (int i = 0; i < 40; i++) begin
         rx_data   = 8'hC0 + DW'(i);
         rx_ready  = 1'b1;
         out_ready = 1'($urandom_range(0, 1));
         step();
         rx_ready  = 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      drain(DEPTH + 4);
      check("t7_stream_len", 32'(dut_stream.size()), 32'(exp_stream.size()));
      for (int i = 0; i < dut_stream.size() && i < exp_stream.size(); i++)
         check("t7_stream", 32'(dut_stream[i]), 32'(exp_stream[i]));
      if (dut_stream.size() != 0) check("t7_first", 32'(dut_stream[0]), 32'hC0);
      check("t7_level", 32'(level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
